// File: rtl/cpu_ifetch.sv
// cpu_ifetch: Falcon P1 fetch stage with 2-entry instruction queue, credit-based issue and redirect discard
module cpu_ifetch #(
  parameter logic [31:0] RESET_PC = 32'hFFFF0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        p2_bubble,
  input  logic        p4_jump_taken,
  input  logic [31:0] p4_jump_addr,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  output logic        p2_instr_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding, discard, q_cnt;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc [2];
  logic [31:0] f_pc [2];
  logic        q_rd, q_wr, f_rd, f_wr;
  logic        jump, advance, accept, live, q_pop, q_push, bypass;
  always_comb begin
    jump = p4_jump_taken && !stall;
    advance = !stall && !p2_bubble && !jump;
    imem_req = reset_n && !jump && ({1'b0, outstanding} + {1'b0, q_cnt} < 3'd2);
    imem_addr = fetch_pc;
    accept = imem_req && imem_ready;
    live = imem_rvalid && discard == 2'd0 && !jump;
    q_pop = advance && q_cnt != 2'd0;
    bypass = advance && q_cnt == 2'd0 && live;
    q_push = live && !bypass;
  end
  always_ff @(posedge clock) begin
    if (accept) f_pc[f_wr] <= fetch_pc;
    if (q_push) begin
      q_instr[q_wr] <= imem_rdata;
      q_pc[q_wr] <= f_pc[f_rd];
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      outstanding <= 2'd0;
      discard <= 2'd0;
      q_cnt <= 2'd0;
      q_rd <= 1'b0;
      q_wr <= 1'b0;
      f_rd <= 1'b0;
      f_wr <= 1'b0;
      p2_instr <= 32'd0;
      p2_pc <= 32'd0;
      p2_instr_valid <= 1'b0;
    end else begin
      outstanding <= outstanding + 2'(accept) - 2'(imem_rvalid);
      if (jump) begin
        fetch_pc <= p4_jump_addr;
        discard <= outstanding - 2'(imem_rvalid);
        q_cnt <= 2'd0;
        q_rd <= q_wr;
        f_rd <= f_wr;
        p2_instr_valid <= 1'b0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
          f_wr <= ~f_wr;
        end
        if (imem_rvalid && discard != 2'd0) discard <= discard - 2'd1;
        if (live) f_rd <= ~f_rd;
        if (q_push) q_wr <= ~q_wr;
        if (q_pop) q_rd <= ~q_rd;
        q_cnt <= q_cnt + 2'(q_push) - 2'(q_pop);
        if (advance) p2_instr_valid <= q_pop || bypass;
        if (q_pop) begin
          p2_instr <= q_instr[q_rd];
          p2_pc <= q_pc[q_rd];
        end else if (bypass) begin
          p2_instr <= imem_rdata;
          p2_pc <= f_pc[f_rd];
        end
      end
    end
  end
endmodule

// File: tb/tb_cpu_ifetch.sv
// tb_cpu_ifetch: table-driven and randomized checks of cpu_ifetch against an in-order instruction stream model
module tb_cpu_ifetch;
  localparam logic [31:0] RESET_PC = 32'hFFFF0000;
  localparam logic [31:0] KEY = 32'h1234;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        p2_bubble = 1'b0;
  logic        p4_jump_taken = 1'b0;
  logic [31:0] p4_jump_addr = 32'd0;
  logic [31:0] p2_instr, p2_pc, imem_addr;
  logic        p2_instr_valid, imem_req;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic stall; logic bubble; logic req; logic valid; logic [31:0] pc; } vec_t;
  mreq_t mq[$];
  vec_t vec[10];
  int cyc = 0, lat = 1, n_chk = 0, n_fail = 0;
  logic [31:0] exp_fetch = RESET_PC, exp_pc = RESET_PC, held;
  logic seen_zero;
  cpu_ifetch #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .p2_bubble(p2_bubble),
    .p4_jump_taken(p4_jump_taken), .p4_jump_addr(p4_jump_addr),
    .p2_instr(p2_instr), .p2_pc(p2_pc), .p2_instr_valid(p2_instr_valid),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic acc, jmp, hold, pv_v;
    logic [31:0] a, pv_pc, pv_instr;
    imem_rvalid = mq.size() > 0 && mq[0].due <= cyc;
    imem_rdata = imem_rvalid ? (mq[0].addr ^ KEY) : 32'hDEADBEEF;
    #1;
    acc = imem_req && imem_ready;
    a = imem_addr;
    jmp = p4_jump_taken && !stall;
    hold = stall || p2_bubble;
    pv_v = p2_instr_valid;
    pv_pc = p2_pc;
    pv_instr = p2_instr;
    if (jmp) check("no_req_on_redirect", 32'(imem_req), 32'd0);
    if (acc) begin
      check("fetch_addr", a, exp_fetch);
      exp_fetch += 32'd4;
    end
    @(posedge clock);
    if (imem_rvalid) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{a, cyc + lat});
      check("max_outstanding", 32'(mq.size() <= 2), 32'd1);
    end
    cyc++;
    #1;
    if (jmp) begin
      check("redirect_kills_p2", 32'(p2_instr_valid), 32'd0);
      exp_pc = p4_jump_addr;
      exp_fetch = p4_jump_addr;
    end else if (hold) begin
      check("hold_valid", 32'(p2_instr_valid), 32'(pv_v));
      check("hold_pc", p2_pc, pv_pc);
      check("hold_instr", p2_instr, pv_instr);
    end else if (p2_instr_valid) begin
      check("stream_pc", p2_pc, exp_pc);
      check("stream_instr", p2_instr, exp_pc ^ KEY);
      exp_pc += 32'd4;
    end
    @(negedge clock);
  endtask
  task automatic wait_valid(input string name);
    int i;
    i = 0;
    tick();
    while (!p2_instr_valid && i < 40) begin
      tick();
      i++;
    end
    if (!p2_instr_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for p2_instr_valid", name);
    end
  endtask
  initial begin
    vec[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vec[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF0000};
    vec[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF0004};
    vec[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF0004};
    vec[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF0004};
    vec[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF0004};
    vec[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF0008};
    vec[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF000C};
    vec[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF0010};
    vec[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF0014};
    #1 reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(p2_instr_valid), 32'd0);
    check("rst_pc", p2_pc, 32'd0);
    check("rst_instr", p2_instr, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      stall = vec[k].stall;
      p2_bubble = vec[k].bubble;
      #1 check("tbl_req", 32'(imem_req), 32'(vec[k].req));
      tick();
      check("tbl_valid", 32'(p2_instr_valid), 32'(vec[k].valid));
      if (vec[k].valid) check("tbl_pc", p2_pc, vec[k].pc);
    end
    p2_bubble = 1'b0;
    p4_jump_taken = 1'b1;
    p4_jump_addr = 32'h00000800;
    tick();
    p4_jump_taken = 1'b0;
    tick();
    check("jmp_lat_j2", 32'(p2_instr_valid), 32'd0);
    tick();
    check("jmp_lat_j3_valid", 32'(p2_instr_valid), 32'd1);
    check("jmp_lat_j3_pc", p2_pc, 32'h00000800);
    lat = 3;
    for (int i = 0; i < 20 && mq.size() != 2; i++) tick();
    check("two_outstanding", 32'(mq.size()), 32'd2);
    p4_jump_taken = 1'b1;
    p4_jump_addr = 32'h00001000;
    tick();
    p4_jump_taken = 1'b0;
    wait_valid("jmp1000");
    check("jmp_target_pc", p2_pc, 32'h00001000);
    wait_valid("jmp1004");
    check("jmp_next_pc", p2_pc, 32'h00001004);
    stall = 1'b1;
    p4_jump_taken = 1'b1;
    p4_jump_addr = 32'h00002000;
    repeat (3) tick();
    stall = 1'b0;
    tick();
    p4_jump_taken = 1'b0;
    wait_valid("jmp2000");
    check("stalled_jump_pc", p2_pc, 32'h00002000);
    lat = 4;
    repeat (4) tick();
    held = p2_pc;
    stall = 1'b1;
    repeat (5) tick();
    check("stall_frozen_pc", p2_pc, held);
    stall = 1'b0;
    repeat (12) tick();
    p4_jump_taken = 1'b1;
    p4_jump_addr = 32'hFFFFFFF0;
    tick();
    p4_jump_taken = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < 60; i++) begin
      imem_ready = 1'($urandom % 2);
      lat = $urandom_range(1, 3);
      tick();
      if (p2_instr_valid && p2_pc == 32'd0) seen_zero = 1'b1;
    end
    check("wrap_seen_zero", 32'(seen_zero), 32'd1);
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 4) == 0;
      p2_bubble = ($urandom % 4) == 0;
      p4_jump_taken = ($urandom % 16) == 0;
      p4_jump_addr = $urandom & 32'hFFFFFFFC;
      imem_ready = ($urandom % 3) != 0;
      lat = $urandom_range(1, 4);
      tick();
    end
    stall = 1'b0;
    p2_bubble = 1'b0;
    p4_jump_taken = 1'b0;
    imem_ready = 1'b1;
    lat = 1;
    repeat (10) tick();
    check("pre_reset_valid", 32'(p2_instr_valid), 32'd1);
    #2 reset_n = 1'b0;
    mq.delete();
    imem_rvalid = 1'b0;
    #1;
    check("async_rst_valid", 32'(p2_instr_valid), 32'd0);
    check("async_rst_addr", imem_addr, RESET_PC);
    check("async_rst_req", 32'(imem_req), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_fetch = RESET_PC;
    exp_pc = RESET_PC;
    wait_valid("restart");
    check("restart_pc", p2_pc, RESET_PC);
    tick();
    check("restart_next_pc", p2_pc, RESET_PC + 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
